// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a master and the apb_slave_mem completer.
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA (master -> slave),
//          PREADY/PRDATA/PSLVERR (slave -> master).
interface apb_slave_mem_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned ADDR_WIDTH = 32;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer serving a MEM_DEPTH x DATA_WIDTH register memory with a
// fixed number of wait states, PSLVERR on misaligned accesses and a sideband
// pulse for master protocol violations.
// Ports: PCLK (clock), PRESETn (synchronous reset, asserted high),
//        apb (slave modport of the APB bus), proto_err (violation pulse).
module apb_slave_mem #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_slave_mem_if.slave       apb,
    output logic                 proto_err
);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic                    proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic                    mem_we;

    logic                    setup;
    logic                    setup_err;
    logic [IDX_W-1:0]        paddr_idx;
    logic [DATA_WIDTH-1:0]   rd_setup;
    logic [DATA_WIDTH-1:0]   rd_latched;
    logic                    unused_paddr;

    assign setup        = apb.PSEL && !apb.PENABLE;
    assign setup_err    = (apb.PADDR[1:0] != 2'b00);
    assign paddr_idx    = apb.PADDR[ADDR_W-1:2];
    assign rd_setup     = mem_q[paddr_idx];
    assign rd_latched   = mem_q[addr_q];
    assign unused_paddr = ^apb.PADDR[31:ADDR_W];

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a setup phase seen in ACCESS restarts the transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (!apb.PSEL)                    state_d = S_IDLE;
                else if (apb.PENABLE && pready_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        pready_d    = pready_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;
        proto_err_d = 1'b0;
        mem_we      = 1'b0;

        if (setup) begin
            // Setup in ACCESS drops the old transfer and latches the new one
            if (state_q == S_ACCESS) proto_err_d = 1'b1;
            addr_d  = paddr_idx;
            write_d = apb.PWRITE;
            wdata_d = apb.PWDATA;
            err_d   = setup_err;
            if (WAIT_CYCLES == 0) begin
                cnt_d     = '0;
                pready_d  = 1'b1;
                pslverr_d = setup_err;
                prdata_d  = (!apb.PWRITE && !setup_err) ? rd_setup : '0;
            end else begin
                cnt_d     = CNT_W'(WAIT_CYCLES);
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only a selected slave treats a bare PENABLE as a violation
                    if (apb.PSEL && apb.PENABLE) proto_err_d = 1'b1;
                end
                S_ACCESS: begin
                    if (!apb.PSEL) begin
                        proto_err_d = 1'b1;
                        cnt_d       = '0;
                        pready_d    = 1'b0;
                        prdata_d    = '0;
                        pslverr_d   = 1'b0;
                    end else if (pready_q) begin
                        mem_we    = write_q && !err_q;
                        pready_d  = 1'b0;
                        prdata_d  = '0;
                        pslverr_d = 1'b0;
                    end else begin
                        if (cnt_q == CNT_W'(1)) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q;
                            prdata_d  = (!write_q && !err_q) ? rd_latched : '0;
                        end
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and memory registers
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            proto_err_q <= proto_err_d;
            if (mem_we) mem_q[addr_q] <= wdata_q;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (WAIT_CYCLES 0, 1, 15) on gated
// copies of one APB master, checked against a word-array reference memory.
module tb_apb_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int unsigned sel;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    logic [31:0] ref_mem [3][64];

    always #5 clk = ~clk;

    apb_slave_mem_if #(.DATA_WIDTH(32)) bus0 ();
    apb_slave_mem_if #(.DATA_WIDTH(32)) bus1 ();
    apb_slave_mem_if #(.DATA_WIDTH(32)) bus2 ();
    logic perr0, perr1, perr2;

    assign bus0.PSEL = psel && (sel == 0);
    assign bus0.PENABLE = penable;
    assign bus0.PWRITE = pwrite;
    assign bus0.PADDR = paddr;
    assign bus0.PWDATA = pwdata;
    assign bus1.PSEL = psel && (sel == 1);
    assign bus1.PENABLE = penable;
    assign bus1.PWRITE = pwrite;
    assign bus1.PADDR = paddr;
    assign bus1.PWDATA = pwdata;
    assign bus2.PSEL = psel && (sel == 2);
    assign bus2.PENABLE = penable;
    assign bus2.PWRITE = pwrite;
    assign bus2.PADDR = paddr;
    assign bus2.PWDATA = pwdata;

    apb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst), .apb(bus0), .proto_err(perr0));
    apb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
        .PCLK(clk), .PRESETn(rst), .apb(bus1), .proto_err(perr1));
    apb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(15)) u_dut2 (
        .PCLK(clk), .PRESETn(rst), .apb(bus2), .proto_err(perr2));

    logic        pready_w  [3];
    logic [31:0] prdata_w  [3];
    logic        pslverr_w [3];
    logic        perr_w    [3];
    assign pready_w[0] = bus0.PREADY;
    assign pready_w[1] = bus1.PREADY;
    assign pready_w[2] = bus2.PREADY;
    assign prdata_w[0] = bus0.PRDATA;
    assign prdata_w[1] = bus1.PRDATA;
    assign prdata_w[2] = bus2.PRDATA;
    assign pslverr_w[0] = bus0.PSLVERR;
    assign pslverr_w[1] = bus1.PSLVERR;
    assign pslverr_w[2] = bus2.PSLVERR;
    assign perr_w[0] = perr0;
    assign perr_w[1] = perr1;
    assign perr_w[2] = perr2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        assert (got === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned wait_of(input int unsigned d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 15);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++)
                ref_mem[d][i] = 32'h0;
    endtask

    task automatic check_outputs_zero(input int unsigned d, input string tag);
        check({tag, "_pready"},  32'(pready_w[d]),  32'h0);
        check({tag, "_prdata"},  prdata_w[d],       32'h0);
        check({tag, "_pslverr"}, 32'(pslverr_w[d]), 32'h0);
        check({tag, "_proto"},   32'(perr_w[d]),    32'h0);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        repeat (ncyc) step();
        model_reset();
        rst = 1'b0;
    endtask

    // One complete APB transfer; bus fields are scrambled during ACCESS
    task automatic xfer(input int unsigned d, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned n;
        bit          err;
        logic [31:0] exp_rd;
        sel = d; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata;
        step();
        penable = 1'b1;
        paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
        n = 1;
        while (!pready_w[d] && n < 40) begin
            step();
            n++;
        end
        err    = (addr[1:0] != 2'b00);
        exp_rd = (!wr && !err) ? ref_mem[d][addr[7:2]] : 32'h0;
        check("access_cycles", n, wait_of(d) + 1);
        check("pslverr", 32'(pslverr_w[d]), 32'(err));
        check("prdata", prdata_w[d], exp_rd);
        check("proto_err_clean", 32'(perr_w[d]), 32'h0);
        if (wr && !err) ref_mem[d][addr[7:2]] = wdata;
        step();
        check("pready_single", 32'(pready_w[d]), 32'h0);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        bit          wr;
        int unsigned d;
        logic [31:0] a32;

        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; sel = 1;

        // Reset state
        do_reset(2);
        for (int unsigned k = 0; k < 3; k++) check_outputs_zero(k, "reset");

        // Single write/read, then back-to-back transfers
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h10, 32'h0);
        step();
        xfer(1, 1'b1, 32'h04, 32'hA5A5A5A5);
        xfer(1, 1'b0, 32'h04, 32'h0);
        xfer(1, 1'b0, 32'h08, 32'h0);

        // Misaligned write leaves memory untouched
        do_reset(1);
        xfer(1, 1'b1, 32'h06, 32'h12345678);
        xfer(1, 1'b0, 32'h04, 32'h0);

        // Wait-state sweep on the 0- and 15-wait instances
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h10, 32'h0);
        xfer(2, 1'b1, 32'h10, 32'hDEADBEEF);
        xfer(2, 1'b0, 32'h10, 32'h0);

        // PENABLE without a setup phase
        step();
        sel = 1; psel = 1'b1; penable = 1'b1;
        step();
        check("no_setup_proto", 32'(perr_w[1]), 32'h1);
        check("no_setup_pready", 32'(pready_w[1]), 32'h0);
        psel = 1'b0; penable = 1'b0;
        step();
        check("no_setup_pulse_end", 32'(perr_w[1]), 32'h0);

        // PSEL dropped in the first access cycle of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h20; pwdata = 32'hFFFFFFFF;
        step();
        psel = 1'b0; penable = 1'b0;
        step();
        check("abort_proto", 32'(perr_w[1]), 32'h1);
        check("abort_pready", 32'(pready_w[1]), 32'h0);
        step();
        check("abort_pulse_end", 32'(perr_w[1]), 32'h0);
        xfer(1, 1'b0, 32'h20, 32'h0);

        // Second setup in ACCESS replaces the pending transfer
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h30; pwdata = 32'h11111111;
        step();
        paddr = 32'h34; pwdata = 32'h22222222;
        step();
        check("resetup_proto", 32'(perr_w[1]), 32'h1);
        check("resetup_wait", 32'(pready_w[1]), 32'h0);
        penable = 1'b1;
        step();
        check("resetup_pready", 32'(pready_w[1]), 32'h1);
        check("resetup_pslverr", 32'(pslverr_w[1]), 32'h0);
        step();
        psel = 1'b0; penable = 1'b0;
        ref_mem[1][32'h34 >> 2] = 32'h22222222;
        xfer(1, 1'b0, 32'h30, 32'h0);
        xfer(1, 1'b0, 32'h34, 32'h0);

        // Reset during the wait cycle of a write
        xfer(1, 1'b1, 32'h3C, 32'h77);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h3C; pwdata = 32'h55;
        step();
        penable = 1'b1;
        rst = 1'b1;
        step();
        check_outputs_zero(1, "mid_reset");
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        step();
        xfer(1, 1'b0, 32'h3C, 32'h0);

        // Randomized transfers against the reference memory
        repeat (60) begin
            d   = $urandom_range(0, 2);
            wr  = 1'($urandom_range(0, 1));
            a32 = $urandom;
            a32[7:2] = 6'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) a32[1:0] = 2'b00;
            xfer(d, wr, a32, $urandom);
            if ($urandom_range(0, 2) == 0) step();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
